// File: rtl/lzd_pkg.sv
// Shared definitions for the leading-zero detect / denormalize datapath.
package lzd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } lzd_state_t;

  // Width of a leading-zero count able to represent 0..width inclusive.
  function automatic int unsigned lzc_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lz_denorm_if.sv
// Input/output valid-ready bundle of the denormalizer.
interface lz_denorm_if
  import lzd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = lzc_width(WIDTH)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mant;
  logic [CW-1:0]    in_lzc;
  logic             in_nz;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Producer/consumer side (environment).
  modport master (
    output in_valid, in_mant, in_lzc, in_nz, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Denormalizer side.
  modport slave (
    input  in_valid, in_mant, in_lzc, in_nz, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lz_denorm_shr_step.sv
// One iteration of the denormalizing shift: up to two bit positions per call.
module shr_step
  import lzd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = lzc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    rem_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    rem_o
);

  // Shift by 2 while at least 2 remain, by 1 for the odd tail, else pass through.
  always_comb begin
    data_o = data_i;
    rem_o  = rem_i;
    if (rem_i >= CW'(2)) begin
      data_o = data_i >> 2;
      rem_o  = rem_i - CW'(2);
    end else if (rem_i == CW'(1)) begin
      data_o = data_i >> 1;
      rem_o  = '0;
    end
  end

endmodule

// File: rtl/lz_denorm.sv
// Iterative denormalizer: restores a fixed-point value from mantissa + leading-zero count.
module lz_denorm
  import lzd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = lzc_width(WIDTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  lz_denorm_if.slave  bus_io
);

  lzd_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] step_data;
  logic [CW-1:0]    step_rem;

  shr_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shr_step (
    .data_i (data_q),
    .rem_i  (rem_q),
    .data_o (step_data),
    .rem_o  (step_rem)
  );

  // Outputs depend on registered state only, so there is no input-to-output path.
  always_comb begin
    bus_io.in_ready  = (state_q == StIdle);
    bus_io.out_valid = (state_q == StDone);
    bus_io.out_data  = data_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          data_d = bus_io.in_mant;
          rem_d  = bus_io.in_lzc;
          // A zero value or a count that shifts everything out yields zero at once.
          if (!bus_io.in_nz || (bus_io.in_lzc >= CW'(WIDTH))) begin
            data_d  = '0;
            state_d = StDone;
          end else if (bus_io.in_lzc == '0) begin
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        data_d = step_data;
        rem_d  = step_rem;
        if (step_rem == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

endmodule
